conv_mem_scheduler: RTL and testbench
=====================================

Name: conv_mem_scheduler

Overview:
Owns the single-port synchronous data RAM of the image-convolution processor and time-shares it across three phases: LOAD (image loader writes pixels), RUN (control unit drives MAR/MBR accesses), DUMP (result words streamed out). It sits between the top level, the RAM and the processor. It raises the processor's enable, watches its finish flag, and guards RUN with a watchdog.

Parameters:
ADDR_W, 16, RAM address width
DATA_W, 8, RAM data width
LOAD_BASE, 0, first RAM address written in LOAD
LOAD_WORDS, 4096, words accepted in LOAD (1..2^ADDR_W)
RESULT_BASE, 4096, first RAM address read in DUMP
RESULT_WORDS, 1024, words streamed in DUMP (1..2^ADDR_W)
RUN_TIMEOUT, 1000000, max RUN cycles before abort (0 = watchdog disabled)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  1-cycle pulse: begin LOAD, accepted only in IDLE or DONE
ld_valid  in  1  loader word valid
ld_data  in  DATA_W  loader pixel
ld_ready  out  1  scheduler accepts loader word
cpu_enable  out  1  processor run enable (level)
cpu_finish  in  1  processor finished (level, sticky in processor)
cpu_req  in  1  processor memory request
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  processor address (MAR)
cpu_wdata  in  DATA_W  processor write data
cpu_rdata  out  DATA_W  read data to MBR
cpu_ack  out  1  request completed
rd_valid  out  1  result word valid
rd_data  out  DATA_W  result word
rd_ready  in  1  consumer accepts result
mem_en, mem_we  out  1 each  RAM strobes
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after mem_en
phase  out  3  one-hot-free encoding of current state (see package)
done  out  1  high in DONE
timeout_err  out  1  sticky: last RUN aborted by watchdog

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; counters 0; timeout_err cleared.
- States: IDLE, LOAD, RUN, DUMP_RD, DUMP_HOLD, DONE.
- IDLE/DONE + start -> LOAD; clears word counter and timeout_err; done drops next cycle. start in any other state is ignored.
- LOAD: ld_ready=1. On ld_valid&&ld_ready: mem_en=mem_we=1, mem_addr=LOAD_BASE+cnt, mem_wdata=ld_data (combinational, same cycle), cnt++. After word LOAD_WORDS-1 is accepted -> RUN; ld_ready=0 from that next cycle.
- RUN: cpu_enable=1 (rises on entry, held). cpu_req sampled in cycle T: mem driven in T; cpu_ack=1 in T+1 for one cycle; for reads cpu_rdata=mem_rdata registered-through in T+1 and held until the next read ack. Back-to-back requests allowed (one per cycle). Watchdog counts RUN cycles.
- RUN exits: cpu_finish=1 -> DUMP_RD (a request in the same cycle still completes; its ack occurs in the first DUMP_RD cycle). Watchdog reaching RUN_TIMEOUT -> timeout_err=1, DUMP_RD. cpu_enable=0 from the first non-RUN cycle.
- cpu_req outside RUN: ignored, no mem access, no ack.
- DUMP_RD: mem_en=1, mem_we=0, mem_addr=RESULT_BASE+cnt -> DUMP_HOLD.
- DUMP_HOLD: first cycle captures mem_rdata into rd_data, rd_valid=1; held stable until rd_ready. On rd_valid&&rd_ready: cnt++; if last word -> DONE, else -> DUMP_RD. Throughput 1 word / 2 cycles minimum.
- DONE: done=1, all request outputs 0; waits for start.
- Address arithmetic: base+cnt modulo 2^ADDR_W (wrap, no error). Counters ADDR_W+1 bits to reach full-size counts.
- Only one requester ever drives the RAM in a cycle; mem_* are 0 when no access.
- rst_n assertion mid-phase: immediate abort, RAM contents untouched, return to IDLE.

Decomposition:
- Package conv_sched_pkg: state encoding constants (IDLE=0, LOAD=1, RUN=2, DUMP_RD=3, DUMP_HOLD=4, DONE=5), phase width constant.
- One sub-module: sched_watchdog (load/clear, enable, terminal-count pulse, disabled when limit=0).

Test Plan:
- Reset mid-LOAD after 2 of 4 words (LOAD_WORDS=4) -> outputs 0, phase=IDLE; new start reloads from address LOAD_BASE.
- LOAD_WORDS=4, ld_data 0x11,0x22,0x33,0x44 with ld_valid gaps -> RAM writes at addrs 0..3 exactly once each; phase=RUN and cpu_enable=1 on the cycle after 0x44.
- RUN: cpu read addr 2 -> cpu_ack one cycle later with cpu_rdata=0x33; cpu write 0x5A to 4097 followed next cycle by a read of 4097 -> second ack returns 0x5A.
- RESULT_BASE=4096, RESULT_WORDS=2, cpu_finish=1 -> rd_data 0xAA then 0x5A; rd_ready held low 3 cycles keeps rd_valid/rd_data stable; then done=1.
- RUN_TIMEOUT=20, cpu_finish never asserted -> timeout_err=1 at cycle 20 of RUN, cpu_enable=0, DUMP proceeds to DONE.
- start during RUN, and cpu_req during LOAD -> both ignored: no phase change, no mem access, no cpu_ack.

Source files
------------

// File: rtl/conv_mem_scheduler_pkg.sv
// Shared state encoding and phase width for the convolution memory scheduler.
package conv_sched_pkg;

    localparam int PHASE_W = 3;

    typedef enum logic [PHASE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_RUN       = 3'd2,
        ST_DUMP_RD   = 3'd3,
        ST_DUMP_HOLD = 3'd4,
        ST_DONE      = 3'd5
    } sched_state_e;

endpackage

// File: rtl/conv_mem_scheduler_watchdog.sv
// RUN-phase watchdog: counts enabled cycles and flags the cycle that reaches LIMIT.
module sched_watchdog #(
    parameter int unsigned LIMIT = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = 32;
    localparam logic [CNT_W-1:0] TC = (LIMIT == 0) ? 32'd0 : CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count_r;

    // Elapsed enabled cycles since the last clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 32'd0;
        end else if (clear) begin
            count_r <= 32'd0;
        end else if (enable && !expired) begin
            count_r <= count_r + 32'd1;
        end else begin
            count_r <= count_r;
        end
    end

    // Terminal-count pulse; a zero limit disables the watchdog entirely.
    always_comb begin
        expired = 1'b0;
        if (LIMIT == 0) begin
            expired = 1'b0;
        end else if (enable && (count_r == TC)) begin
            expired = 1'b1;
        end else begin
            expired = 1'b0;
        end
    end

endmodule

// File: rtl/conv_mem_scheduler.sv
// Time-shares the single-port data RAM between image load, processor run and result dump.
module conv_mem_scheduler
    import conv_sched_pkg::*;
#(
    parameter int          ADDR_W       = 16,
    parameter int          DATA_W       = 8,
    parameter int unsigned LOAD_BASE    = 0,
    parameter int unsigned LOAD_WORDS   = 4096,
    parameter int unsigned RESULT_BASE  = 4096,
    parameter int unsigned RESULT_WORDS = 1024,
    parameter int unsigned RUN_TIMEOUT  = 1000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               ld_valid,
    input  logic [DATA_W-1:0]  ld_data,
    output logic               ld_ready,
    output logic               cpu_enable,
    input  logic               cpu_finish,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [DATA_W-1:0]  cpu_wdata,
    output logic [DATA_W-1:0]  cpu_rdata,
    output logic               cpu_ack,
    output logic               rd_valid,
    output logic [DATA_W-1:0]  rd_data,
    input  logic               rd_ready,
    output logic               mem_en,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic [PHASE_W-1:0] phase,
    output logic               done,
    output logic               timeout_err
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LOAD_BASE_A   = ADDR_W'(LOAD_BASE);
    localparam logic [ADDR_W-1:0] RESULT_BASE_A = ADDR_W'(RESULT_BASE);
    localparam logic [CNT_W-1:0]  LOAD_LAST     = CNT_W'(LOAD_WORDS - 1);
    localparam logic [CNT_W-1:0]  RESULT_LAST   = CNT_W'(RESULT_WORDS - 1);

    sched_state_e      state_r;
    sched_state_e      state_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic              timeout_err_r;
    logic              cpu_ack_r;
    logic              cpu_rd_pend_r;
    logic [DATA_W-1:0] cpu_rdata_r;
    logic              hold_first_r;
    logic [DATA_W-1:0] rd_data_r;
    logic              start_ok_s;
    logic              ld_fire_s;
    logic              cpu_fire_s;
    logic              rd_fire_s;
    logic              wd_expired_s;
    logic              run_s;

    assign run_s      = (state_r == ST_RUN);
    assign start_ok_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign ld_fire_s  = (state_r == ST_LOAD) && ld_valid;
    assign cpu_fire_s = run_s && cpu_req;
    assign rd_fire_s  = (state_r == ST_DUMP_HOLD) && rd_ready;

    sched_watchdog #(
        .LIMIT (RUN_TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!run_s),
        .enable  (run_s),
        .expired (wd_expired_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) state_nxt_s = ST_LOAD;
                else       state_nxt_s = state_r;
            end
            ST_LOAD: begin
                if (ld_fire_s && (cnt_r == LOAD_LAST)) state_nxt_s = ST_RUN;
                else                                   state_nxt_s = ST_LOAD;
            end
            ST_RUN: begin
                if (cpu_finish || wd_expired_s) state_nxt_s = ST_DUMP_RD;
                else                            state_nxt_s = ST_RUN;
            end
            ST_DUMP_RD: begin
                state_nxt_s = ST_DUMP_HOLD;
            end
            ST_DUMP_HOLD: begin
                if (rd_fire_s && (cnt_r == RESULT_LAST)) state_nxt_s = ST_DONE;
                else if (rd_fire_s)                      state_nxt_s = ST_DUMP_RD;
                else                                     state_nxt_s = ST_DUMP_HOLD;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Word counter shared by LOAD and DUMP; it is zero whenever RUN starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (start_ok_s) begin
            cnt_r <= '0;
        end else if (ld_fire_s) begin
            cnt_r <= (cnt_r == LOAD_LAST) ? '0 : cnt_r + 1'b1;
        end else if (rd_fire_s) begin
            cnt_r <= (cnt_r == RESULT_LAST) ? '0 : cnt_r + 1'b1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Sticky watchdog abort flag, cleared only by a new start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err_r <= 1'b0;
        end else if (start_ok_s) begin
            timeout_err_r <= 1'b0;
        end else if (run_s && wd_expired_s) begin
            timeout_err_r <= 1'b1;
        end else begin
            timeout_err_r <= timeout_err_r;
        end
    end

    // Processor ack pipeline and read-data holding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_ack_r     <= 1'b0;
            cpu_rd_pend_r <= 1'b0;
            cpu_rdata_r   <= '0;
            hold_first_r  <= 1'b0;
            rd_data_r     <= '0;
        end else begin
            cpu_ack_r     <= cpu_fire_s;
            cpu_rd_pend_r <= cpu_fire_s && !cpu_we;
            cpu_rdata_r   <= cpu_rd_pend_r ? mem_rdata : cpu_rdata_r;
            hold_first_r  <= (state_r == ST_DUMP_RD);
            rd_data_r     <= hold_first_r ? mem_rdata : rd_data_r;
        end
    end

    // RAM read data is only valid in the cycle after the access, so pass it through then.
    assign cpu_rdata   = cpu_rd_pend_r ? mem_rdata : cpu_rdata_r;
    assign cpu_ack     = cpu_ack_r;
    assign phase       = state_r;
    assign timeout_err = timeout_err_r;

    // Per-state output decode; exactly one requester owns the RAM port.
    always_comb begin
        ld_ready   = 1'b0;
        cpu_enable = 1'b0;
        rd_valid   = 1'b0;
        rd_data    = '0;
        done       = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_r)
            ST_LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = LOAD_BASE_A + cnt_r[ADDR_W-1:0];
                    mem_wdata = ld_data;
                end else begin
                    mem_en = 1'b0;
                end
            end
            ST_RUN: begin
                cpu_enable = 1'b1;
                if (cpu_req) begin
                    mem_en    = 1'b1;
                    mem_we    = cpu_we;
                    mem_addr  = cpu_addr;
                    mem_wdata = cpu_we ? cpu_wdata : '0;
                end else begin
                    mem_en = 1'b0;
                end
            end
            ST_DUMP_RD: begin
                mem_en   = 1'b1;
                mem_addr = RESULT_BASE_A + cnt_r[ADDR_W-1:0];
            end
            ST_DUMP_HOLD: begin
                rd_valid = 1'b1;
                rd_data  = hold_first_r ? mem_rdata : rd_data_r;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                done = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_conv_mem_scheduler.sv
// Self-checking bench for conv_mem_scheduler: table-driven load, directed RUN/DUMP, randomized runs vs a RAM-content model.
module tb_conv_mem_scheduler;
    import conv_sched_pkg::*;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int LW     = 4;
    localparam int RB     = 4096;
    localparam int RW     = 2;
    localparam int TO     = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic ld_valid = 1'b0;
    logic [DATA_W-1:0] ld_data = '0;
    logic ld_ready, cpu_enable, cpu_ack, rd_valid, mem_en, mem_we, done, timeout_err;
    logic cpu_finish = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0, rd_ready = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic [DATA_W-1:0] cpu_rdata, rd_data, mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [ADDR_W-1:0] mem_addr;
    logic [PHASE_W-1:0] phase;

    conv_mem_scheduler #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOAD_BASE(0), .LOAD_WORDS(LW),
        .RESULT_BASE(RB), .RESULT_WORDS(RW), .RUN_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .cpu_enable(cpu_enable), .cpu_finish(cpu_finish),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_ready(rd_ready), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .phase(phase), .done(done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Environment RAM (synchronous, single port) plus write counters for addresses 0..3.
    logic [DATA_W-1:0] ram [0:65535];
    int wcount [0:3];
    logic wc_clr = 1'b0;
    always @(posedge clk) begin
        if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
        for (int k = 0; k < 4; k++) begin
            if (wc_clr) wcount[k] <= 0;
            else if (mem_en && mem_we && (mem_addr == 16'(k))) wcount[k] <= wcount[k] + 1;
        end
    end

    // Reference model: expected RAM contents and processor-port expectations.
    logic [DATA_W-1:0] ref_mem [int];
    bit pend_ack = 1'b0, pend_rd = 1'b0;
    logic [DATA_W-1:0] pend_data = '0, last_rd = '0;
    int n_checks = 0, n_err = 0;

    function automatic logic [DATA_W-1:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_phase"}, 32'(phase), 32'(ST_IDLE));
        chk({tag, "_ld_ready"}, 32'(ld_ready), 32'd0);
        chk({tag, "_cpu_enable"}, 32'(cpu_enable), 32'd0);
        chk({tag, "_cpu_ack"}, 32'(cpu_ack), 32'd0);
        chk({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'd0);
        chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
        chk({tag, "_mem_en"}, 32'(mem_en), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    endtask

    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1; ld_valid = 1'b0; cpu_req = 1'b0; rd_ready = 1'b0; cpu_finish = 1'b0;
    endtask

    // Random-gap load of LW words starting at LOAD_BASE; cpu_req here must be ignored.
    task automatic do_load();
        for (int i = 0; i < LW; i++) begin
            int gaps;
            gaps = $urandom_range(0, 2);
            repeat (gaps) begin
                @(negedge clk);
                start = 1'b0; ld_valid = 1'b0; cpu_req = 1'($urandom_range(0, 1)); cpu_we = 1'b1;
                cpu_addr = 16'(RB); cpu_wdata = 8'hEE;
                #1;
                chk("load_gap_phase", 32'(phase), 32'(ST_LOAD));
                chk("load_gap_mem_en", 32'(mem_en), 32'd0);
                chk("load_gap_ack", 32'(cpu_ack), 32'd0);
                chk("load_gap_done", 32'(done), 32'd0);
            end
            @(negedge clk);
            start = 1'b0; ld_valid = 1'b1; ld_data = 8'($urandom); cpu_req = 1'($urandom_range(0, 1));
            #1;
            chk("load_ready", 32'(ld_ready), 32'd1);
            chk("load_mem_en", 32'(mem_en & mem_we), 32'd1);
            chk("load_addr", 32'(mem_addr), 32'(i));
            chk("load_wdata", 32'(mem_wdata), 32'(ld_data));
            chk("load_ack", 32'(cpu_ack), 32'd0);
            ref_mem[i] = ld_data;
        end
    endtask

    // One RUN cycle with the given processor request; model predicts ack/rdata/mem strobes.
    task automatic run_cycle(input bit req, input bit we, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] wd, input bit fin, input bit st,
                             input int cyc, output bit ex);
        @(negedge clk);
        start = st; ld_valid = 1'($urandom_range(0, 1)); rd_ready = 1'($urandom_range(0, 1));
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_finish = fin;
        #1;
        chk("run_phase", 32'(phase), 32'(ST_RUN));
        chk("run_cpu_enable", 32'(cpu_enable), 32'd1);
        chk("run_ld_ready", 32'(ld_ready), 32'd0);
        chk("run_ack", 32'(cpu_ack), 32'(pend_ack));
        if (pend_ack && pend_rd) last_rd = pend_data;
        chk("run_rdata", 32'(cpu_rdata), 32'(last_rd));
        chk("run_mem_en", 32'(mem_en), 32'(req));
        if (req) begin
            chk("run_mem_we", 32'(mem_we), 32'(we));
            chk("run_mem_addr", 32'(mem_addr), 32'(a));
            if (we) chk("run_mem_wdata", 32'(mem_wdata), 32'(wd));
        end
        pend_ack = req;
        pend_rd  = req && !we;
        if (req && we) ref_mem[int'(a)] = wd;
        if (req && !we) pend_data = ref_rd(int'(a));
        ex = fin || (cyc == TO);
    endtask

    // First cycle after RUN: DUMP_RD issues the first result read, late ack lands here.
    task automatic post_run(input bit exp_to);
        @(negedge clk);
        start = 1'b0; cpu_req = 1'b0; cpu_finish = 1'b0; ld_valid = 1'b0; rd_ready = 1'b0;
        #1;
        chk("dump_rd_phase", 32'(phase), 32'(ST_DUMP_RD));
        chk("dump_cpu_enable", 32'(cpu_enable), 32'd0);
        chk("dump_late_ack", 32'(cpu_ack), 32'(pend_ack));
        if (pend_ack && pend_rd) last_rd = pend_data;
        chk("dump_late_rdata", 32'(cpu_rdata), 32'(last_rd));
        chk("timeout_err", 32'(timeout_err), 32'(exp_to));
        chk("dump_rd_strobe", 32'({mem_en, mem_we}), 32'b10);
        chk("dump_rd_addr", 32'(mem_addr), 32'(RB));
        pend_ack = 1'b0;
        pend_rd  = 1'b0;
    endtask

    // Drain RW result words with stalls (stall < 0: random), ending in DONE.
    task automatic do_dump(input int stall, output logic [DATA_W-1:0] g0, output logic [DATA_W-1:0] g1);
        logic [DATA_W-1:0] data;
        bit seen;
        int st;
        g0 = '0; g1 = '0;
        for (int w = 0; w < RW; w++) begin
            seen = 1'b0;
            for (int t = 0; t < 6; t++) begin
                @(negedge clk);
                rd_ready = 1'b0;
                #1;
                if (rd_valid) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("dump_valid_seen", 32'(seen), 32'd1);
            data = rd_data;
            chk("dump_phase", 32'(phase), 32'(ST_DUMP_HOLD));
            chk("dump_data", 32'(rd_data), 32'(ref_rd(RB + w)));
            st = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
            repeat (st) begin
                @(negedge clk);
                #1;
                chk("dump_hold_valid", 32'(rd_valid), 32'd1);
                chk("dump_hold_data", 32'(rd_data), 32'(data));
            end
            rd_ready = 1'b1;
            if (w == 0) g0 = data;
            else        g1 = data;
        end
        @(negedge clk);
        rd_ready = 1'b0;
        #1;
        chk("done_phase", 32'(phase), 32'(ST_DONE));
        chk("done_flag", 32'(done), 32'd1);
        chk("done_quiet", 32'({mem_en, rd_valid, cpu_enable, ld_ready}), 32'd0);
    endtask

    typedef struct {
        bit                v;
        logic [DATA_W-1:0] d;
        bit                req;
        bit                e_en;
        logic [ADDR_W-1:0] e_addr;
    } ld_vec_t;

    ld_vec_t ltab [6];

    initial begin
        #100000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        bit ex;
        bit never;
        int fin_at;
        logic [DATA_W-1:0] g0, g1;

        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;

        ltab[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 16'd0};
        ltab[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 16'd0};
        ltab[2] = '{1'b1, 8'h22, 1'b0, 1'b1, 16'd1};
        ltab[3] = '{1'b1, 8'h33, 1'b0, 1'b1, 16'd2};
        ltab[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 16'd0};
        ltab[5] = '{1'b1, 8'h44, 1'b0, 1'b1, 16'd3};

        // Reset state.
        #12;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Abort mid-LOAD after two words.
        start_pulse();
        @(negedge clk);
        start = 1'b0; ld_valid = 1'b1; ld_data = 8'hC1;
        #1;
        chk("mid_w0_addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        ld_data = 8'hC2;
        #1;
        chk("mid_w1_addr", 32'(mem_addr), 32'd1);
        @(negedge clk);
        ld_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        chk("midreset_ram0", 32'(ram[0]), 32'hC1);
        chk("midreset_ram1", 32'(ram[1]), 32'hC2);
        ref_mem[0] = 8'hC1;
        ref_mem[1] = 8'hC2;
        @(negedge clk);
        rst_n = 1'b1;
        wc_clr = 1'b1;

        // Table-driven reload with gaps and an ignored cpu_req.
        start_pulse();
        wc_clr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = 1'b0; ld_valid = ltab[i].v; ld_data = ltab[i].d;
            cpu_req = ltab[i].req; cpu_we = 1'b1; cpu_addr = 16'(RB + 1); cpu_wdata = 8'h77;
            #1;
            chk("tab_phase", 32'(phase), 32'(ST_LOAD));
            chk("tab_ld_ready", 32'(ld_ready), 32'd1);
            chk("tab_mem_en", 32'(mem_en), 32'(ltab[i].e_en));
            chk("tab_mem_we", 32'(mem_we), 32'(ltab[i].e_en));
            chk("tab_mem_addr", 32'(mem_addr), 32'(ltab[i].e_addr));
            chk("tab_mem_wdata", 32'(mem_wdata), ltab[i].e_en ? 32'(ltab[i].d) : 32'd0);
            chk("tab_cpu_ack", 32'(cpu_ack), 32'd0);
            if (ltab[i].v) ref_mem[int'(ltab[i].e_addr)] = ltab[i].d;
        end

        // Directed RUN: read, write/read-back, ignored start, then finish.
        run_cycle(1'b1, 1'b0, 16'd2, 8'h00, 1'b0, 1'b0, 1, ex);
        run_cycle(1'b1, 1'b1, 16'd4097, 8'h5A, 1'b0, 1'b0, 2, ex);
        chk("dir_read2", 32'(cpu_rdata), 32'h33);
        run_cycle(1'b1, 1'b0, 16'd4097, 8'h00, 1'b0, 1'b1, 3, ex);
        run_cycle(1'b1, 1'b1, 16'd4096, 8'hAA, 1'b0, 1'b0, 4, ex);
        chk("dir_read4097", 32'(cpu_rdata), 32'h5A);
        chk("dir_ack4097", 32'(cpu_ack), 32'd1);
        run_cycle(1'b0, 1'b0, 16'd0, 8'h00, 1'b1, 1'b0, 5, ex);
        for (int k = 0; k < 4; k++) chk("load_write_once", 32'(wcount[k]), 32'd1);
        post_run(1'b0);
        do_dump(3, g0, g1);
        chk("dir_result0", 32'(g0), 32'hAA);
        chk("dir_result1", 32'(g1), 32'h5A);

        // Randomized runs; run 0 always exercises the watchdog.
        for (int r = 0; r < 6; r++) begin
            start_pulse();
            do_load();
            never  = (r == 0) || ($urandom_range(0, 3) == 0);
            fin_at = never ? 1000 : int'($urandom_range(3, 18));
            for (int cyc = 1; cyc <= TO; cyc++) begin
                logic [ADDR_W-1:0] a;
                a = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 3)) : 16'(RB + $urandom_range(0, 1));
                run_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 8'($urandom),
                          cyc == fin_at, $urandom_range(0, 7) == 0, cyc, ex);
                if (ex) break;
            end
            post_run(never);
            do_dump(-1, g0, g1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
